// File: rtl/sample_block_reader_if.sv
// Sample-bus and output-stream signals of the block reader, bundled with
// the reader (master) and environment (slave) views.
interface sample_block_reader_if;
  logic        req;
  logic        req_busy;
  logic        sample_start;
  logic        sample_busy;
  logic [5:0]  sample_raddr;
  logic [31:0] sample_rdata;
  logic [31:0] timestamp;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
  logic        timeout_err;

  modport master (
    input  req, sample_busy, sample_rdata, out_ready,
    output req_busy, sample_start, sample_raddr, timestamp,
           out_data, out_valid, out_last, done, timeout_err
  );

  modport slave (
    output req, sample_busy, sample_rdata, out_ready,
    input  req_busy, sample_start, sample_raddr, timestamp,
           out_data, out_valid, out_last, done, timeout_err
  );
endinterface

// File: rtl/sample_block_reader.sv
// Triggers a snapshot on the sample bus, waits for the responder, then streams
// a sequence header followed by NUM_QUADS quadlets read from the sample buffer.
module sample_block_reader #(
  parameter int NUM_QUADS    = 5,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                  sysclk,
  input  logic                  reset,
  sample_block_reader_if.master bus
);
  localparam int              CW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [5:0]      NQ6      = 6'(NUM_QUADS);
  localparam logic [5:0]      LAST_IDX = 6'(NUM_QUADS - 1);
  localparam logic [CW-1:0]   TMO      = CW'(BUSY_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ARM, S_WAIT, S_HDR, S_ADDR, S_FETCH, S_SEND, S_DONE
  } state_t;

  state_t        r_state;
  logic [5:0]    r_idx;
  logic [15:0]   r_seq;
  logic [31:0]   r_timestamp;
  logic [CW-1:0] r_wait_cnt;
  logic          r_req_busy;
  logic          r_sample_start;
  logic [5:0]    r_raddr;
  logic [31:0]   r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_done;
  logic          r_timeout_err;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) r_timestamp <= '0;
    else       r_timestamp <= r_timestamp + 32'd1;
  end

  // Outputs are registered: each transition loads the values seen in the next state.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_seq          <= '0;
      r_wait_cnt     <= '0;
      r_req_busy     <= 1'b0;
      r_sample_start <= 1'b0;
      r_raddr        <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_sample_start <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_state        <= S_START;
            r_sample_start <= 1'b1;
            r_req_busy     <= 1'b1;
            r_timeout_err  <= 1'b0;
            r_wait_cnt     <= '0;
          end
        end
        S_START: r_state <= S_ARM;
        // ARM gives the responder a cycle to raise sample_busy.
        S_ARM:   r_state <= S_WAIT;
        S_WAIT: begin
          if (!bus.sample_busy) begin
            r_state     <= S_HDR;
            r_out_data  <= {r_seq, 10'd0, NQ6};
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end else if (r_wait_cnt == TMO) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_HDR: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_raddr     <= '0;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR:  r_state <= S_FETCH;
        S_FETCH: begin
          r_out_data  <= bus.sample_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_idx == LAST_IDX);
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 6'd1;
              r_raddr <= r_idx + 6'd1;
              r_state <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          if (!r_timeout_err) r_seq <= r_seq + 16'd1;
          r_req_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_busy     = r_req_busy;
  assign bus.sample_start = r_sample_start;
  assign bus.sample_raddr = r_raddr;
  assign bus.timestamp    = r_timestamp;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_last     = r_out_last;
  assign bus.done         = r_done;
  assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_sample_block_reader.sv
// Directed bench for sample_block_reader: responder model, stream collector,
// table of request scenarios plus reset and wrap sequences.
module tb_sample_block_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_block_reader_if bus();

  sample_block_reader #(.NUM_QUADS(5), .BUSY_TIMEOUT(1023)) dut (
    .sysclk (clk),
    .reset  (rst),
    .bus    (bus.master)
  );

  typedef struct {
    string       name;
    bit          slow;
    int          busy_len;
    bit          stuck;
    bit          poke;
    logic [31:0] exp_hdr;
    int          exp_n;
    bit          exp_to;
    int          exp_lat;
    int          budget;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, start_cnt = 0, valid_cnt = 0;
  logic [31:0] q_data[$];
  bit          q_last[$];
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data;
  bit          stall_last;
  int          busy_left = 0;
  int          busy_len = 10;
  bit          busy_stuck = 1'b0;
  logic [5:0]  raddr_d = '0;
  bit          ready_slow = 1'b0;
  int          rcyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Stream collector, hold checker and sample-bus responder, all on the falling edge.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.sample_start) start_cnt++;
    if (bus.out_valid) valid_cnt++;
    if (stall_prev && !rst) begin
      check1("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", bus.out_data, stall_data);
      check1("hold_last", bus.out_last, stall_last);
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
    stall_last = bus.out_last;
    if (bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_last.push_back(bus.out_last);
    end
    bus.sample_rdata = 32'hA000_0000 + {26'd0, raddr_d};
    raddr_d = bus.sample_raddr;
    if (bus.sample_start) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    bus.sample_busy = busy_stuck || (busy_left != 0);
  end

  always @(posedge clk) begin
    #1;
    rcyc++;
    bus.out_ready = ready_slow ? (rcyc % 3 == 0) : 1'b1;
  end

  task automatic run_vec(input vec_t v);
    int n, lat, d0, s0, v0;
    bit poked;
    busy_len   = v.busy_len;
    busy_stuck = v.stuck;
    ready_slow = v.slow;
    q_data.delete();
    q_last.delete();
    d0 = done_cnt; s0 = start_cnt; v0 = valid_cnt;
    @(posedge clk); #1 bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    @(negedge clk);
    check1({v.name, ".busy_on"}, bus.req_busy, 1'b1);
    check1({v.name, ".to_clr"}, bus.timeout_err, 1'b0);
    n = 0; lat = -1; poked = 1'b0;
    while (!bus.done && n < v.budget) begin
      if (bus.out_valid && lat < 0) lat = n;
      if (bus.req) bus.req = 1'b0;
      else if (v.poke && (n == 4 || (bus.out_valid && q_data.size() == 2 && !poked))) begin
        bus.req = 1'b1;
        if (n != 4) poked = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.req = 1'b0;
    check1({v.name, ".done"}, bus.done, 1'b1);
    if (v.stuck) check1({v.name, ".to_cycles"}, (n >= 1025 && n <= 1030), 1'b1);
    if (v.exp_lat >= 0) check({v.name, ".latency"}, lat, v.exp_lat);
    repeat (6) @(negedge clk);
    check({v.name, ".done_cnt"}, done_cnt - d0, 1);
    check({v.name, ".start_cnt"}, start_cnt - s0, 1);
    check1({v.name, ".timeout_err"}, bus.timeout_err, v.exp_to);
    check1({v.name, ".busy_off"}, bus.req_busy, 1'b0);
    check({v.name, ".nwords"}, q_data.size(), v.exp_n);
    if (v.exp_n == 0) check({v.name, ".no_valid"}, valid_cnt - v0, 0);
    if (v.exp_n > 0 && q_data.size() == v.exp_n) begin
      check({v.name, ".hdr"}, q_data[0], v.exp_hdr);
      check1({v.name, ".hdr_last"}, q_last[0], 1'b0);
      for (int i = 1; i < v.exp_n; i++) begin
        check($sformatf("%s.d%0d", v.name, i - 1), q_data[i], 32'hA000_0000 + 32'(i - 1));
        check1($sformatf("%s.l%0d", v.name, i - 1), q_last[i], i == v.exp_n - 1);
      end
    end
    $display("req %s: words=%0d cycles=%0d timeout_err=%b", v.name, q_data.size(), n, bus.timeout_err);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, ".req_busy"}, bus.req_busy, 1'b0);
    check1({tag, ".sample_start"}, bus.sample_start, 1'b0);
    check({tag, ".raddr"}, {26'd0, bus.sample_raddr}, 32'd0);
    check({tag, ".timestamp"}, bus.timestamp, 32'd0);
    check({tag, ".out_data"}, bus.out_data, 32'd0);
    check1({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check1({tag, ".out_last"}, bus.out_last, 1'b0);
    check1({tag, ".done"}, bus.done, 1'b0);
    check1({tag, ".timeout_err"}, bus.timeout_err, 1'b0);
  endtask

  vec_t vecs[5];
  vec_t vpost;

  initial begin
    int n, d0;
    vecs[0] = '{"basic",   1'b0, 10, 1'b0, 1'b0, 32'h0000_0005, 6, 1'b0, -1, 200};
    vecs[1] = '{"slowrdy", 1'b1, 10, 1'b0, 1'b0, 32'h0001_0005, 6, 1'b0, -1, 300};
    vecs[2] = '{"timeout", 1'b0,  0, 1'b1, 1'b0, 32'h0000_0000, 0, 1'b1, -1, 1200};
    vecs[3] = '{"poke",    1'b0, 10, 1'b0, 1'b1, 32'h0002_0005, 6, 1'b0, -1, 200};
    vecs[4] = '{"nobusy",  1'b0,  0, 1'b0, 1'b0, 32'h0003_0005, 6, 1'b0,  3, 200};

    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check("ts_first", bus.timestamp, 32'd1);
    @(negedge clk);
    check("ts_next", bus.timestamp, 32'd2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a block: no done, and the next block starts clean.
    ready_slow = 1'b0; busy_len = 10; busy_stuck = 1'b0;
    q_data.delete(); q_last.delete();
    d0 = done_cnt;
    @(posedge clk); #1 bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    n = 0;
    while (!(bus.out_valid && q_data.size() >= 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1("mid_send_reached", n < 200, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.no_done", done_cnt - d0, 0);
    $display("reset in SEND after %0d words", q_data.size());
    vpost = '{"after_rst", 1'b0, 10, 1'b0, 1'b0, 32'h0000_0005, 6, 1'b0, -1, 200};
    run_vec(vpost);

    // Wrap of the sequence number and the timestamp.
    @(negedge clk);
    force dut.r_seq = 16'hFFFF;
    force dut.r_timestamp = 32'hFFFF_FFFE;
    #1;
    release dut.r_seq;
    release dut.r_timestamp;
    check("ts_fffe", bus.timestamp, 32'hFFFF_FFFE);
    @(negedge clk);
    check("ts_ffff", bus.timestamp, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ts_wrap", bus.timestamp, 32'h0000_0000);
    vpost = '{"seq_ffff", 1'b0, 10, 1'b0, 1'b0, 32'hFFFF_0005, 6, 1'b0, -1, 200};
    run_vec(vpost);
    vpost = '{"seq_wrap", 1'b0, 10, 1'b0, 1'b0, 32'h0000_0005, 6, 1'b0, -1, 200};
    run_vec(vpost);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
